// File: rtl/axis_word_packer.sv
// axis_word_packer: packs an 8-bit AXI-Stream byte stream into 64-bit words.
// A partial word that sits idle for TIMEOUT_CYCLES cycles is discarded so
// that framing resynchronises on the next byte.
module axis_word_packer #(
  parameter int unsigned TIMEOUT_CYCLES = 100000,
  parameter bit          MSB_FIRST      = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  s_axis_tdata,
  input  logic        s_axis_tvalid,
  output logic        s_axis_tready,
  output logic [63:0] m_axis_tdata,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  output logic [2:0]  byte_count,
  output logic        timeout_pulse
);

  localparam int unsigned WORD_W = 64;
  localparam int unsigned CNT_W  = 3;
  localparam int unsigned TMO_W  = 24;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_HOLD    = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [WORD_W-1:0]  data_q,  data_d;
  logic [CNT_W-1:0]   cnt_q,   cnt_d;
  logic [TMO_W-1:0]   tmo_q,   tmo_d;
  logic               rdy_q,   rdy_d;
  logic               vld_q,   vld_d;
  logic               pulse_q, pulse_d;

  logic               accept_c;
  logic [CNT_W-1:0]   lane_c;
  logic [WORD_W-1:0]  placed_c;

  // Byte handshake and the incoming byte shifted into its lane
  always_comb begin
    accept_c = s_axis_tvalid & rdy_q;
    lane_c   = MSB_FIRST ? CNT_W'(3'd7 - cnt_q) : cnt_q;
    placed_c = WORD_W'(s_axis_tdata) << {lane_c, 3'b000};
  end

  // Next-state, assembly, idle timer and registered-output decode
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    tmo_d   = '0;
    pulse_d = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (accept_c) begin
          // New word: lanes not yet written start from zero
          data_d  = placed_c;
          cnt_d   = CNT_W'(1);
          state_d = S_COLLECT;
        end
      end
      S_COLLECT: begin
        if (accept_c) begin
          data_d = data_q | placed_c;
          if (cnt_q == CNT_W'(7)) begin
            cnt_d   = '0;
            state_d = S_HOLD;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end else if (tmo_q == TMO_LAST) begin
          // Drop the stale partial word entirely
          data_d  = '0;
          cnt_d   = '0;
          pulse_d = 1'b1;
          state_d = S_IDLE;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      S_HOLD: begin
        if (vld_q && m_axis_tready) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    rdy_d = (state_d != S_HOLD);
    vld_d = (state_d == S_HOLD);
  end

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      data_q  <= '0;
      cnt_q   <= '0;
      tmo_q   <= '0;
      rdy_q   <= 1'b0;
      vld_q   <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      tmo_q   <= tmo_d;
      rdy_q   <= rdy_d;
      vld_q   <= vld_d;
      pulse_q <= pulse_d;
    end
  end

  assign s_axis_tready = rdy_q;
  assign m_axis_tdata  = data_q;
  assign m_axis_tvalid = vld_q;
  assign byte_count    = cnt_q;
  assign timeout_pulse = pulse_q;

endmodule

// File: tb/tb_axis_word_packer.sv
// tb_axis_word_packer: two packers (MSB-first and LSB-first, short timeout)
// driven by the same byte stream and checked against a queue-based model.
module tb_axis_word_packer;

  localparam int unsigned TMO = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  s_tdata;
  logic        s_tvalid;
  logic        m_tready;

  logic        s_tready_a, s_tready_b;
  logic [63:0] m_tdata_a,  m_tdata_b;
  logic        m_tvalid_a, m_tvalid_b;
  logic [2:0]  cnt_a,      cnt_b;
  logic        pulse_a,    pulse_b;

  int n_cmp = 0;
  int n_bad = 0;

  axis_word_packer #(.TIMEOUT_CYCLES(TMO), .MSB_FIRST(1'b1)) dut_a (
    .clk(clk), .rst(rst),
    .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready_a),
    .m_axis_tdata(m_tdata_a), .m_axis_tvalid(m_tvalid_a), .m_axis_tready(m_tready),
    .byte_count(cnt_a), .timeout_pulse(pulse_a)
  );

  axis_word_packer #(.TIMEOUT_CYCLES(TMO), .MSB_FIRST(1'b0)) dut_b (
    .clk(clk), .rst(rst),
    .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready_b),
    .m_axis_tdata(m_tdata_b), .m_axis_tvalid(m_tvalid_b), .m_axis_tready(m_tready),
    .byte_count(cnt_b), .timeout_pulse(pulse_b)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: bytes of the partial word, idle time, pending word
  logic [7:0]  q_bytes[$];
  int          idle_e  = 0;
  bit          hold_e  = 1'b0;
  bit          rdy_e   = 1'b0;
  bit          pulse_e = 1'b0;
  logic [63:0] w_msb   = '0;
  logic [63:0] w_lsb   = '0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      q_bytes.delete();
      idle_e  = 0;
      hold_e  = 1'b0;
      rdy_e   = 1'b0;
      pulse_e = 1'b0;
    end else begin
      pulse_e = 1'b0;
      if (hold_e) begin
        if (m_tready) hold_e = 1'b0;
      end else if (s_tvalid && rdy_e) begin
        q_bytes.push_back(s_tdata);
        idle_e = 0;
        if (q_bytes.size() == 8) begin
          w_msb = '0;
          w_lsb = '0;
          foreach (q_bytes[k]) begin
            w_msb = w_msb | (64'(q_bytes[k]) << (56 - 8 * k));
            w_lsb = w_lsb | (64'(q_bytes[k]) << (8 * k));
          end
          hold_e = 1'b1;
          q_bytes.delete();
        end
      end else if (q_bytes.size() > 0) begin
        if (idle_e == int'(TMO) - 1) begin
          q_bytes.delete();
          idle_e  = 0;
          pulse_e = 1'b1;
        end else begin
          idle_e++;
        end
      end
      rdy_e = !hold_e;
    end
  end

  // Per-cycle comparison of both packers against the model
  always @(negedge clk) begin
    if (rst) begin
      check("rst_s_tready", 64'(s_tready_a | s_tready_b), 64'd0);
      check("rst_m_tvalid", 64'(m_tvalid_a | m_tvalid_b), 64'd0);
      check("rst_m_tdata",  m_tdata_a | m_tdata_b, 64'd0);
      check("rst_count",    64'(cnt_a | cnt_b), 64'd0);
      check("rst_pulse",    64'(pulse_a | pulse_b), 64'd0);
    end else begin
      check("s_tready_a", 64'(s_tready_a), 64'(rdy_e));
      check("s_tready_b", 64'(s_tready_b), 64'(rdy_e));
      check("m_tvalid_a", 64'(m_tvalid_a), 64'(hold_e));
      check("m_tvalid_b", 64'(m_tvalid_b), 64'(hold_e));
      check("count_a",    64'(cnt_a), 64'(q_bytes.size()));
      check("count_b",    64'(cnt_b), 64'(q_bytes.size()));
      check("pulse_a",    64'(pulse_a), 64'(pulse_e));
      check("pulse_b",    64'(pulse_b), 64'(pulse_e));
      if (hold_e) begin
        check("m_tdata_a", m_tdata_a, w_msb);
        check("m_tdata_b", m_tdata_b, w_lsb);
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Offer one byte and wait (bounded) for its handshake
  task automatic send(input logic [7:0] b);
    bit got;
    got      = 1'b0;
    s_tvalid = 1'b1;
    s_tdata  = b;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk);
      got = s_tready_a;
      @(posedge clk);
      #1;
    end
    if (!got) begin
      n_cmp++;
      n_bad++;
      $display("FAIL send_handshake: byte %h never accepted", b);
    end
    s_tvalid = 1'b0;
  endtask

  // Send bytes first..last of w, counting bytes from the top of w
  task automatic send_seq(input logic [63:0] w, input int first, input int last);
    for (int k = first; k <= last; k++) send(w[63 - 8 * k -: 8]);
  endtask

  initial begin
    int first_pulse;
    int n_pulse;
    int gap;

    rst      = 1'b1;
    s_tvalid = 1'b0;
    s_tdata  = '0;
    m_tready = 1'b1;
    repeat (3) cyc();
    rst = 1'b0;
    check("post_rst_ready_before_edge", 64'(s_tready_a), 64'd0);
    cyc();
    check("post_rst_ready_first_edge", 64'(s_tready_a), 64'd1);

    // Back-to-back word, downstream always ready
    send_seq(64'hfeedfacedeadbeef, 0, 7);
    check("w1_valid", 64'(m_tvalid_a), 64'd1);
    check("w1_msb",   m_tdata_a, 64'hfeedfacedeadbeef);
    check("w1_lsb",   m_tdata_b, 64'hefbeaddecefaedfe);
    cyc();
    check("w1_valid_one_cycle", 64'(m_tvalid_a), 64'd0);

    // Backpressure with a 9th byte waiting
    m_tready = 1'b0;
    send_seq(64'hfeedfacedeadbeef, 0, 7);
    s_tvalid = 1'b1;
    s_tdata  = 8'h11;
    for (int i = 0; i < 20; i++) begin
      check("hold_ready", 64'(s_tready_a), 64'd0);
      check("hold_data",  m_tdata_a, 64'hfeedfacedeadbeef);
      cyc();
    end
    m_tready = 1'b1;
    send(8'h11);
    check("after_hold_count", 64'(cnt_a), 64'd1);
    for (int k = 2; k <= 8; k++) send(8'(k * 8'h11));
    check("w2_msb", m_tdata_a, 64'h1122334455667788);
    check("w2_lsb", m_tdata_b, 64'h8877665544332211);

    // Three bytes then silence: timeout
    send(8'ha1); send(8'ha2); send(8'ha3);
    check("tmo_count_before", 64'(cnt_a), 64'd3);
    first_pulse = -1;
    n_pulse     = 0;
    for (int i = 1; i <= 22; i++) begin
      cyc();
      if (pulse_a) begin
        n_pulse++;
        if (first_pulse < 0) first_pulse = i;
        check("tmo_count_at_pulse", 64'(cnt_a), 64'd0);
      end
    end
    check("tmo_latency", 64'(first_pulse), 64'd16);
    check("tmo_npulse",  64'(n_pulse), 64'd1);
    send_seq(64'h0102030405060708, 0, 7);
    check("w3_msb", m_tdata_a, 64'h0102030405060708);
    check("w3_lsb", m_tdata_b, 64'h0807060504030201);

    // Fourth byte lands exactly on the expiry cycle
    send_seq(64'hb1b2b3b4c5c6c7c8, 0, 2);
    repeat (15) cyc();
    send(8'hb4);
    check("edge_count", 64'(cnt_a), 64'd4);
    check("edge_no_pulse", 64'(pulse_a), 64'd0);
    send_seq(64'hb1b2b3b4c5c6c7c8, 4, 7);
    check("w4_msb", m_tdata_a, 64'hb1b2b3b4c5c6c7c8);

    // Asynchronous reset mid-word
    cyc();
    send_seq(64'h5555555555555555, 0, 4);
    #1 rst = 1'b1;
    #1;
    check("arst_ready",  64'(s_tready_a), 64'd0);
    check("arst_valid",  64'(m_tvalid_a), 64'd0);
    check("arst_data_a", m_tdata_a, 64'd0);
    check("arst_data_b", m_tdata_b, 64'd0);
    check("arst_count",  64'(cnt_a), 64'd0);
    check("arst_pulse",  64'(pulse_a), 64'd0);
    #1 rst = 1'b0;
    cyc();
    check("arst_ready_after", 64'(s_tready_a), 64'd1);
    send_seq(64'ha0a1a2a3a4a5a6a7, 0, 7);
    check("w5_msb", m_tdata_a, 64'ha0a1a2a3a4a5a6a7);
    check("w5_lsb", m_tdata_b, 64'ha7a6a5a4a3a2a1a0);

    // Random traffic with bursts of silence around the timeout length
    gap = 0;
    for (int c = 0; c < 4000; c++) begin
      if (gap > 0) begin
        s_tvalid = 1'b0;
        gap--;
      end else begin
        s_tvalid = ($urandom_range(0, 3) != 0);
        if ($urandom_range(0, 40) == 0) gap = $urandom_range(10, 25);
      end
      s_tdata  = 8'($urandom);
      m_tready = ($urandom_range(0, 2) != 0);
      cyc();
    end
    s_tvalid = 1'b0;
    m_tready = 1'b1;
    repeat (5) cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/axis_word_packer.md
AXIS_WORD_PACKER -- requirements
Module: axis_word_packer

Purpose: gathers the 8-bit byte stream from the UART receiver into 64-bit words and presents them on a 64-bit AXI-Stream master port. An inter-byte timeout resynchronises framing.

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 100000, is the number of idle clk cycles within a partial word after which the partial word is discarded (range 2..2^24-1).
REQ-002 Parameter MSB_FIRST, default 1: when 1, the first received byte lands in [63:56]; when 0, it lands in [7:0].
REQ-003 clk  input  1  single system clock; all logic is on its rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 s_axis_tdata  input  8  received byte.
REQ-006 s_axis_tvalid  input  1  byte valid.
REQ-007 s_axis_tready  output  1  packer can accept a byte.
REQ-008 m_axis_tdata  output  64  assembled word.
REQ-009 m_axis_tvalid  output  1  word valid.
REQ-010 m_axis_tready  input  1  downstream accepts the word.
REQ-011 byte_count  output  3  number of bytes held in the current partial word (0..7).
REQ-012 timeout_pulse  output  1  one-cycle strobe when a partial word is discarded.

Function
REQ-013 The FSM SHALL have three states:
- IDLE: no bytes held.
- COLLECT: 1..7 bytes held.
- HOLD: full word presented.
REQ-014 A byte SHALL be accepted only on a cycle where s_axis_tvalid=1 and s_axis_tready=1.
REQ-015 s_axis_tready SHALL be 1 in IDLE and COLLECT, and 0 in HOLD.
REQ-016 IDLE SHALL go to COLLECT on an accepted byte, with byte_count=1 on the next cycle.
REQ-017 In COLLECT, each accepted byte SHALL increment byte_count.
REQ-018 In COLLECT, acceptance of the 8th byte SHALL move the FSM to HOLD and return byte_count to 0.
REQ-019 Byte placement for the k-th accepted byte (k=0..7):
- MSB_FIRST=1: byte goes to bits [63-8k:56-8k].
- MSB_FIRST=0: byte goes to bits [8k+7:8k].
REQ-020 m_axis_tvalid SHALL assert on the clock edge that accepts the 8th byte, so it is visible the cycle after the handshake (latency 1 cycle).
REQ-021 m_axis_tvalid is asserted only in HOLD.
REQ-022 m_axis_tdata SHALL remain stable while m_axis_tvalid=1 and until the handshake completes.
REQ-023 HOLD SHALL go to IDLE on the cycle after m_axis_tvalid=1 and m_axis_tready=1.
REQ-024 m_axis_tvalid SHALL NOT depend combinationally on m_axis_tready.
REQ-025 Timeout counter behaviour:
- Runs only in COLLECT.
- Clears to 0 on every accepted byte and on entry to COLLECT.
- Increments on every cycle in COLLECT with no accepted byte.
REQ-026 When the timeout counter reaches TIMEOUT_CYCLES-1 with no byte accepted that cycle:
- the partial word is discarded;
- byte_count returns to 0;
- timeout_pulse=1 for exactly one cycle;
- the FSM returns to IDLE.
REQ-027 If a byte is accepted on the same cycle the counter would expire, the byte SHALL be kept and no timeout occurs.
REQ-028 The timeout counter SHALL be held at 0 in IDLE and HOLD; HOLD waits for m_axis_tready indefinitely.
REQ-029 Data bits of discarded partial words SHALL NOT appear in any later m_axis_tdata.
REQ-030 Unused assembly bits SHALL be zeroed when a new word starts, so every output word contains only its own 8 bytes.

Reset
REQ-031 While rst=1, outputs SHALL be: s_axis_tready=0, m_axis_tvalid=0, m_axis_tdata=0, byte_count=0, timeout_pulse=0.
REQ-032 While rst=1, the FSM is in IDLE and the timeout counter is 0.
REQ-033 Assertion of rst SHALL take effect immediately, without waiting for a clk edge, including mid-word and in HOLD; any partial or held word is lost.
REQ-034 On the first clk edge after rst deasserts, s_axis_tready SHALL become 1.

Verification
REQ-035 MSB_FIRST=1, bytes fe ed fa ce de ad be ef back-to-back, m_axis_tready=1 -> one word 64'hfeedfacedeadbeef, m_axis_tvalid high exactly 1 cycle, starting the cycle after the 8th byte.
REQ-036 MSB_FIRST=0, same bytes -> word 64'hefbeaddecefaedfe.
REQ-037 Same bytes, m_axis_tready=0 for 20 cycles then 1; a 9th byte 0x11 is offered throughout -> s_axis_tready=0 while in HOLD; the word holds steady; 0x11 becomes byte 0 of the next word after the handshake.
REQ-038 TIMEOUT_CYCLES=16, 3 bytes then silence -> timeout_pulse exactly 16 cycles after the 3rd byte, byte_count 3->0; the next 8 bytes 01..08 give 64'h0102030405060708.
REQ-039 TIMEOUT_CYCLES=16, the 4th byte arrives exactly on the expiry cycle -> no timeout_pulse, byte_count=4.
REQ-040 rst pulsed asynchronously (between edges) after 5 bytes -> outputs go to reset values at once; the following 8 bytes produce a clean word with no leftover data.
